// File: rtl/path_turn_scheduler.sv
`default_nettype none
// path_turn_scheduler: buffers a planned node path and, at start and at each
// node, converts the next hop into a relative turn for the motor controller. Rev 1.0
module path_turn_scheduler #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_DIR = 0
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       path_valid,
  input  logic [4:0] path_node,
  input  logic       path_last,
  output logic       path_ready,
  input  logic       start,
  input  logic       node_flag,
  output logic       turn_valid,
  output logic [1:0] turn_cmd,
  input  logic       turn_ack,
  output logic [4:0] cur_node,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_TWO  = LEN_W'(2);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [1:0]       HEAD_INIT = 2'(INIT_DIR);
  localparam logic [4:0]       NO_NODE  = 5'd31;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    READY     = 3'd2,
    LOOKUP    = 3'd3,
    ISSUE     = 3'd4,
    WAIT_NODE = 3'd5,
    ERR       = 3'd6
  } state_t;

  // Arena map: neighbour of node in heading dir (0=N 1=E 2=S 3=W), 31 if none.
  function automatic logic [4:0] adj(input logic [4:0] node, input logic [1:0] dir);
    logic [19:0] row;  // {W, S, E, N}
    case (node)
      5'd0:    row = {5'd7,  5'd31, 5'd31, 5'd1 };
      5'd1:    row = {5'd2,  5'd0,  5'd29, 5'd31};
      5'd2:    row = {5'd4,  5'd31, 5'd1,  5'd8 };
      5'd3:    row = {5'd31, 5'd4,  5'd8,  5'd31};
      5'd4:    row = {5'd31, 5'd5,  5'd2,  5'd3 };
      5'd5:    row = {5'd31, 5'd31, 5'd6,  5'd4 };
      5'd6:    row = {5'd5,  5'd31, 5'd7,  5'd31};
      5'd7:    row = {5'd6,  5'd31, 5'd0,  5'd31};
      5'd8:    row = {5'd3,  5'd2,  5'd31, 5'd9 };
      5'd9:    row = {5'd31, 5'd8,  5'd10, 5'd14};
      5'd10:   row = {5'd9,  5'd29, 5'd11, 5'd31};
      5'd11:   row = {5'd10, 5'd31, 5'd15, 5'd12};
      5'd12:   row = {5'd13, 5'd11, 5'd31, 5'd20};
      5'd13:   row = {5'd14, 5'd31, 5'd12, 5'd31};
      5'd14:   row = {5'd31, 5'd9,  5'd13, 5'd31};
      5'd15:   row = {5'd11, 5'd16, 5'd31, 5'd31};
      5'd16:   row = {5'd31, 5'd17, 5'd31, 5'd15};
      5'd17:   row = {5'd18, 5'd31, 5'd31, 5'd16};
      5'd18:   row = {5'd19, 5'd31, 5'd17, 5'd31};
      5'd19:   row = {5'd31, 5'd31, 5'd18, 5'd31};
      5'd20:   row = {5'd31, 5'd12, 5'd31, 5'd21};
      5'd21:   row = {5'd31, 5'd20, 5'd22, 5'd31};
      5'd22:   row = {5'd21, 5'd31, 5'd23, 5'd31};
      5'd23:   row = {5'd22, 5'd24, 5'd31, 5'd31};
      5'd24:   row = {5'd31, 5'd25, 5'd31, 5'd23};
      5'd25:   row = {5'd26, 5'd31, 5'd31, 5'd24};
      5'd26:   row = {5'd27, 5'd31, 5'd25, 5'd31};
      5'd27:   row = {5'd31, 5'd31, 5'd26, 5'd28};
      5'd28:   row = {5'd31, 5'd27, 5'd31, 5'd31};
      5'd29:   row = {5'd1,  5'd31, 5'd31, 5'd10};
      default: row = {4{NO_NODE}};
    endcase
    case (dir)
      2'd0:    return row[4:0];
      2'd1:    return row[9:5];
      2'd2:    return row[14:10];
      default: return row[19:15];
    endcase
  endfunction

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       dir_q, dir_d;
  logic [1:0]       head_q, head_d;
  logic [1:0]       turn_q, turn_d;
  logic [4:0]       cur_q, cur_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             flag_q;
  logic [4:0]       buf_q [MAX_LEN];
  logic [4:0]       buf_d [MAX_LEN];

  logic       accept;
  logic       flag_rise;
  logic [4:0] probe;

  assign path_ready = (state_q == IDLE) || (state_q == LOAD);
  assign turn_valid = (state_q == ISSUE);
  assign turn_cmd   = turn_q;
  assign cur_node   = cur_q;
  assign busy       = (state_q == LOOKUP) || (state_q == ISSUE) || (state_q == WAIT_NODE);
  assign done       = done_q;
  assign error      = err_q;

  assign accept    = path_valid && path_ready;
  assign flag_rise = node_flag && !flag_q;
  assign probe     = adj(buf_q[idx_q], dir_q);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    head_d  = head_q;
    turn_d  = turn_q;
    cur_d   = cur_q;
    done_d  = done_q;
    err_d   = err_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          buf_d[0] = path_node;
          len_d    = LEN_ONE;
          done_d   = 1'b0;
          state_d  = path_last ? READY : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (len_q == LEN_MAX) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            buf_d[len_q[IDX_W-1:0]] = path_node;
            len_d = len_q + LEN_ONE;
            if (path_last) state_d = READY;
          end
        end
      end
      READY: begin
        if (start) begin
          if (len_q < LEN_TWO) begin
            err_d   = 1'b1;
            state_d = ERR;
          end else begin
            idx_d   = '0;
            dir_d   = 2'd0;
            head_d  = HEAD_INIT;
            cur_d   = buf_q[0];
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        // The probe result of 31 means "no road" and never counts as a match.
        if (flag_rise) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else if (probe != NO_NODE && probe == buf_q[idx_q + IDX_ONE]) begin
          turn_d  = dir_q - head_q;
          head_d  = dir_q;
          state_d = ISSUE;
        end else if (dir_q == 2'd3) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          dir_d = dir_q + 2'd1;
        end
      end
      ISSUE: begin
        if (flag_rise) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else if (turn_ack) begin
          idx_d   = idx_q + IDX_ONE;
          state_d = WAIT_NODE;
        end
      end
      WAIT_NODE: begin
        if (flag_rise) begin
          cur_d = buf_q[idx_q];
          if ({1'b0, idx_q} == len_q - LEN_ONE) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            dir_d   = 2'd0;
            state_d = LOOKUP;
          end
        end
      end
      ERR:     state_d = ERR;
      default: state_d = ERR;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      dir_q   <= '0;
      head_q  <= HEAD_INIT;
      turn_q  <= '0;
      cur_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      head_q  <= head_d;
      turn_q  <= turn_d;
      cur_q   <= cur_d;
      done_q  <= done_d;
      err_q   <= err_d;
      flag_q  <= node_flag;
    end
  end

  // Path storage carries no reset; its contents are rewritten before use.
  always_ff @(posedge clk_50M) begin
    buf_q <= buf_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_path_turn_scheduler.sv
`default_nettype none
// tb_path_turn_scheduler: table vectors, directed corner sequences and random
// arena walks checked against an edge-list model of the map.
module tb_path_turn_scheduler;

  logic       clk;
  logic       rst_n;
  logic       path_valid;
  logic [4:0] path_node;
  logic       path_last;
  logic       path_ready;
  logic       start;
  logic       node_flag;
  logic       turn_valid;
  logic [1:0] turn_cmd;
  logic       turn_ack;
  logic [4:0] cur_node;
  logic       busy;
  logic       done;
  logic       error;

  path_turn_scheduler #(.MAX_LEN(16), .INIT_DIR(0)) dut (
    .clk_50M(clk), .rst_n(rst_n), .path_valid(path_valid), .path_node(path_node),
    .path_last(path_last), .path_ready(path_ready), .start(start), .node_flag(node_flag),
    .turn_valid(turn_valid), .turn_cmd(turn_cmd), .turn_ack(turn_ack),
    .cur_node(cur_node), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Undirected roads: {from, heading from->to, to}
  int edges [33][3];
  int madj  [30][4];

  int cur_n;
  int cur_path [16];
  int exp_turn [16];
  int exp_err_hop;

  typedef struct {
    int n;
    int nodes [8];
    int turns [8];
    int err_hop;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic build_map();
    edges = '{'{0,0,1}, '{1,3,2}, '{1,1,29}, '{2,0,8}, '{8,0,9}, '{9,1,10}, '{10,2,29},
              '{10,1,11}, '{11,0,12}, '{12,3,13}, '{13,3,14}, '{14,2,9}, '{8,3,3},
              '{3,2,4}, '{4,1,2}, '{4,2,5}, '{5,1,6}, '{6,1,7}, '{7,1,0}, '{11,1,15},
              '{15,2,16}, '{16,2,17}, '{17,3,18}, '{18,3,19}, '{12,0,20}, '{20,0,21},
              '{21,1,22}, '{22,1,23}, '{23,2,24}, '{24,2,25}, '{25,3,26}, '{26,3,27},
              '{27,0,28}};
    for (int n = 0; n < 30; n++)
      for (int d = 0; d < 4; d++) madj[n][d] = 31;
    foreach (edges[e]) begin
      madj[edges[e][0]][edges[e][1]] = edges[e][2];
      madj[edges[e][2]][(edges[e][1] + 2) % 4] = edges[e][0];
    end
  endtask

  // Expected turns follow from absolute headings; heading starts north.
  task automatic model_path();
    int head;
    int found;
    head = 0;
    exp_err_hop = -1;
    if (cur_n < 2) begin
      exp_err_hop = 0;
      return;
    end
    for (int k = 0; k < cur_n - 1; k++) begin
      found = -1;
      for (int d = 0; d < 4; d++)
        if (found < 0 && madj[cur_path[k]][d] == cur_path[k+1]) found = d;
      if (found < 0) begin
        exp_err_hop = k;
        return;
      end
      exp_turn[k] = (found - head + 4) % 4;
      head = found;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; path_valid = 0; path_node = 0; path_last = 0;
    start = 0; node_flag = 0; turn_ack = 0;
    repeat (2) @(negedge clk);
    check("rst_path_ready", path_ready, 1);
    check("rst_outputs", {turn_valid, turn_cmd, cur_node, busy, done, error}, 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_path();
    for (int k = 0; k < cur_n; k++) begin
      path_valid = 1'b1;
      path_node  = 5'(cur_path[k]);
      path_last  = (k == cur_n - 1);
      @(negedge clk);
      if (k == 0) check("done_clear_on_load", done, 0);
    end
    path_valid = 1'b0;
    path_last  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_turn_valid();
    int t;
    t = 0;
    while (!turn_valid && t < 8) begin
      @(negedge clk);
      t++;
    end
    check("turn_valid_seen", turn_valid, 1);
  endtask

  task automatic run_path();
    int t;
    int hops;
    bit saw_tv;
    load_path();
    check("ready_low_after_load", path_ready, 0);
    path_valid = 1'b1; path_node = 5'd31;
    @(negedge clk);
    path_valid = 1'b0;
    pulse_start();
    hops = (cur_n < 2) ? 1 : cur_n - 1;
    for (int k = 0; k < hops; k++) begin
      if (k == exp_err_hop) begin
        t = 0; saw_tv = 0;
        while (!error && t < 8) begin
          if (turn_valid) saw_tv = 1;
          @(negedge clk);
          t++;
        end
        check("error_on_bad_hop", error, 1);
        check("no_turn_on_bad_hop", {saw_tv, turn_valid}, 0);
        return;
      end
      wait_turn_valid();
      check("turn_cmd", turn_cmd, exp_turn[k]);
      check("busy_in_issue", busy, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      turn_ack = 1'b1;
      @(negedge clk);
      turn_ack = 1'b0;
      check("turn_valid_drop_after_ack", turn_valid, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      node_flag = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      node_flag = 1'b0;
      @(negedge clk);
      check("cur_node_advance", cur_node, cur_path[k+1]);
    end
    check("done_at_end", done, 1);
    check("error_clear_at_end", error, 0);
    check("busy_low_at_end", busy, 0);
  endtask

  task automatic set_path4(input int a, input int b, input int c, input int d);
    cur_n = 4;
    cur_path[0] = a; cur_path[1] = b; cur_path[2] = c; cur_path[3] = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cmd0;
    int bad;
    int nb [$];
    build_map();

    vecs[0].n = 4; vecs[0].nodes = '{0,1,2,8,0,0,0,0};    vecs[0].turns = '{0,3,1,0,0,0,0,0}; vecs[0].err_hop = -1;
    vecs[1].n = 2; vecs[1].nodes = '{0,5,0,0,0,0,0,0};    vecs[1].turns = '{0,0,0,0,0,0,0,0}; vecs[1].err_hop = 0;
    vecs[2].n = 5; vecs[2].nodes = '{7,0,1,29,10,0,0,0};  vecs[2].turns = '{1,3,1,3,0,0,0,0}; vecs[2].err_hop = -1;
    vecs[3].n = 3; vecs[3].nodes = '{2,1,2,0,0,0,0,0};    vecs[3].turns = '{1,2,0,0,0,0,0,0}; vecs[3].err_hop = -1;
    vecs[4].n = 5; vecs[4].nodes = '{9,8,3,4,5,0,0,0};    vecs[4].turns = '{2,1,3,0,0,0,0,0}; vecs[4].err_hop = -1;
    vecs[5].n = 4; vecs[5].nodes = '{19,18,17,16,0,0,0,0}; vecs[5].turns = '{1,0,3,0,0,0,0,0}; vecs[5].err_hop = -1;
    vecs[6].n = 1; vecs[6].nodes = '{3,0,0,0,0,0,0,0};    vecs[6].turns = '{0,0,0,0,0,0,0,0}; vecs[6].err_hop = 0;
    vecs[7].n = 3; vecs[7].nodes = '{0,1,13,0,0,0,0,0};   vecs[7].turns = '{0,0,0,0,0,0,0,0}; vecs[7].err_hop = 1;

    for (int v = 0; v < 8; v++) begin
      do_reset();
      cur_n = vecs[v].n;
      for (int k = 0; k < 8; k++) begin
        cur_path[k] = vecs[v].nodes[k];
        exp_turn[k] = vecs[v].turns[k];
      end
      exp_err_hop = vecs[v].err_hop;
      run_path();
    end

    // Turn held through a 20-cycle ack stall
    do_reset();
    set_path4(0, 1, 2, 8);
    load_path();
    pulse_start();
    wait_turn_valid();
    cmd0 = int'(turn_cmd);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (turn_valid !== 1'b1 || int'(turn_cmd) != cmd0) bad++;
    end
    check("stall_unstable_cycles", bad, 0);
    check("stall_turn_cmd", turn_cmd, 0);
    turn_ack = 1'b1;
    @(negedge clk);
    turn_ack = 1'b0;
    check("stall_valid_drop", turn_valid, 0);

    // Non-adjacent hop: error exactly four cycles after LOOKUP entry
    do_reset();
    cur_n = 2; cur_path[0] = 0; cur_path[1] = 5;
    load_path();
    pulse_start();
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      check("nonadj_error_early", error, 0);
    end
    @(negedge clk);
    check("nonadj_error_at_4", error, 1);
    check("nonadj_no_turn", turn_valid, 0);

    // Overlong path: 17th beat faults
    do_reset();
    for (int k = 0; k < 17; k++) begin
      path_valid = 1'b1; path_node = 5'(k); path_last = 1'b0;
      @(negedge clk);
      if (k == 15) check("overflow_not_yet", error, 0);
    end
    path_valid = 1'b0;
    check("overflow_error", error, 1);
    check("overflow_ready_low", path_ready, 0);

    // Single-node path
    do_reset();
    cur_n = 1; cur_path[0] = 3;
    load_path();
    pulse_start();
    check("short_path_error", error, 1);

    // Node flag while a turn is pending
    do_reset();
    set_path4(0, 1, 2, 8);
    load_path();
    pulse_start();
    wait_turn_valid();
    node_flag = 1'b1;
    @(negedge clk);
    node_flag = 1'b0;
    check("flag_in_issue_error", error, 1);
    check("flag_in_issue_valid", turn_valid, 0);

    // Level-high node flag advances once
    do_reset();
    set_path4(0, 1, 2, 8);
    load_path();
    pulse_start();
    wait_turn_valid();
    turn_ack = 1'b1;
    @(negedge clk);
    turn_ack = 1'b0;
    node_flag = 1'b1;
    repeat (10) @(negedge clk);
    check("level_flag_cur_node", cur_node, 1);
    check("level_flag_no_error", error, 0);
    check("level_flag_next_turn", {turn_valid, turn_cmd}, {1'b1, 2'd3});
    node_flag = 1'b0;

    // Asynchronous reset mid-issue, then a clean run
    do_reset();
    set_path4(0, 1, 2, 8);
    load_path();
    pulse_start();
    wait_turn_valid();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", turn_valid, 0);
    check("async_rst_ready", path_ready, 1);
    check("async_rst_busy", busy, 0);
    @(negedge clk);
    do_reset();
    set_path4(0, 1, 2, 8);
    model_path();
    run_path();

    // Random walks over the arena
    for (int r = 0; r < 40; r++) begin
      if (error) do_reset();
      cur_n = ($urandom_range(0, 7) == 0) ? 1 : int'($urandom_range(2, 10));
      cur_path[0] = $urandom_range(0, 29);
      for (int k = 1; k < cur_n; k++) begin
        nb.delete();
        for (int d = 0; d < 4; d++)
          if (madj[cur_path[k-1]][d] != 31) nb.push_back(madj[cur_path[k-1]][d]);
        if ($urandom_range(0, 7) == 0) cur_path[k] = $urandom_range(0, 29);
        else cur_path[k] = nb[$urandom_range(0, nb.size() - 1)];
      end
      model_path();
      run_path();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
